// File: rtl/dmem_arbiter_if.sv
// Requester and data-memory bus of the dmem_arbiter, grouped for port connection.
// slave: the arbiter side; master: the side that drives requests and models memory.
interface dmem_arbiter_if;
    logic       req0;
    logic       req1;
    logic       we0;
    logic       we1;
    logic [5:0] adrs0;
    logic [5:0] adrs1;
    logic [7:0] wdata0;
    logic [7:0] wdata1;
    logic       ack0;
    logic       ack1;
    logic [7:0] rdata0;
    logic [7:0] rdata1;
    logic [5:0] mem_adrs;
    logic [7:0] mem_data;
    logic       mem_mode;
    logic [7:0] mem_out;
    logic       busy;
    logic       gnt_id;

    modport slave (
        input  req0, req1, we0, we1, adrs0, adrs1, wdata0, wdata1, mem_out,
        output ack0, ack1, rdata0, rdata1, mem_adrs, mem_data, mem_mode, busy, gnt_id
    );

    modport master (
        output req0, req1, we0, we1, adrs0, adrs1, wdata0, wdata1, mem_out,
        input  ack0, ack1, rdata0, rdata1, mem_adrs, mem_data, mem_mode, busy, gnt_id
    );
endinterface

// File: rtl/dmem_arbiter.sv
// Two-requester arbiter for a 64x8 data memory; DMEM_ARB_ROUND_ROBIN_EN selects round-robin over fixed priority.
// Latency from the IDLE cycle that samples req to ack: 3 cycles for a read, 4 for a write.
// A losing requester is stalled by withholding ack; it holds req and its fields until ack.
module dmem_arbiter (
    input  logic          clk,
    input  logic          rst_n,
    dmem_arbiter_if.slave bus
);
    typedef enum logic [1:0] {IDLE, READ, WRITE, DONE} state_t;

    state_t     state_q;
    logic [1:0] cnt_q;
    logic       gnt_q;
    logic       busy_q;
    logic       mem_mode_q;
    logic       ack0_q;
    logic       ack1_q;
    logic [5:0] adrs_q;
    logic [7:0] wdata_q;
    logic [7:0] rdata0_q;
    logic [7:0] rdata1_q;

    logic       gnt_vld_d;
    logic       gnt_sel_d;
    logic       req_we_d;
    logic [5:0] req_adrs_d;
    logic [7:0] req_wdata_d;

`ifdef DMEM_ARB_ROUND_ROBIN_EN
    logic rr_ptr_q;  // requester favoured on the next collision

    always_comb begin
        gnt_vld_d = bus.req0 | bus.req1;
        gnt_sel_d = (bus.req0 & bus.req1) ? rr_ptr_q : bus.req1;
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            rr_ptr_q <= 1'b0;
        end else if (state_q == IDLE && gnt_vld_d) begin
            rr_ptr_q <= ~gnt_sel_d;
        end
    end
`else
    always_comb begin
        gnt_vld_d = bus.req0 | bus.req1;
        gnt_sel_d = ~bus.req0;
    end
`endif

    always_comb begin
        req_we_d    = gnt_sel_d ? bus.we1    : bus.we0;
        req_adrs_d  = gnt_sel_d ? bus.adrs1  : bus.adrs0;
        req_wdata_d = gnt_sel_d ? bus.wdata1 : bus.wdata0;
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q    <= IDLE;
            cnt_q      <= 2'd0;
            gnt_q      <= 1'b0;
            busy_q     <= 1'b0;
            mem_mode_q <= 1'b0;
            ack0_q     <= 1'b0;
            ack1_q     <= 1'b0;
            adrs_q     <= 6'd0;
            wdata_q    <= 8'd0;
            rdata0_q   <= 8'd0;
            rdata1_q   <= 8'd0;
        end else begin
            ack0_q <= 1'b0;
            ack1_q <= 1'b0;
            case (state_q)
                IDLE: begin
                    if (gnt_vld_d) begin
                        gnt_q   <= gnt_sel_d;
                        adrs_q  <= req_adrs_d;
                        wdata_q <= req_wdata_d;
                        busy_q  <= 1'b1;
                        cnt_q   <= 2'd0;
                        if (req_we_d) begin
                            state_q    <= WRITE;
                            mem_mode_q <= 1'b1;
                        end else begin
                            state_q <= READ;
                        end
                    end
                end
                READ: begin
                    // mem_out has had two full cycles to settle on adrs_q
                    if (cnt_q == 2'd1) begin
                        if (gnt_q) rdata1_q <= bus.mem_out;
                        else       rdata0_q <= bus.mem_out;
                        ack0_q  <= ~gnt_q;
                        ack1_q  <= gnt_q;
                        state_q <= DONE;
                        cnt_q   <= 2'd0;
                    end else begin
                        cnt_q <= cnt_q + 2'd1;
                    end
                end
                WRITE: begin
                    if (cnt_q == 2'd2) begin
                        mem_mode_q <= 1'b0;
                        ack0_q     <= ~gnt_q;
                        ack1_q     <= gnt_q;
                        state_q    <= DONE;
                        cnt_q      <= 2'd0;
                    end else begin
                        cnt_q <= cnt_q + 2'd1;
                    end
                end
                DONE: begin
                    busy_q  <= 1'b0;
                    state_q <= IDLE;
                    cnt_q   <= 2'd0;
                end
                default: begin
                    state_q <= IDLE;
                end
            endcase
        end
    end

    assign bus.ack0     = ack0_q;
    assign bus.ack1     = ack1_q;
    assign bus.rdata0   = rdata0_q;
    assign bus.rdata1   = rdata1_q;
    assign bus.mem_adrs = adrs_q;
    assign bus.mem_data = wdata_q;
    assign bus.mem_mode = mem_mode_q;
    assign bus.busy     = busy_q;
    assign bus.gnt_id   = gnt_q;
endmodule

// File: tb/tb_dmem_arbiter.sv
// Bench for dmem_arbiter: transaction-level model of grant order, latency and memory contents,
// with a behavioural 64x8 memory whose read data lands one edge after the address.
module tb_dmem_arbiter;
    logic clk   = 1'b0;
    logic rst_n = 1'b0;
    always #5 clk = ~clk;

    dmem_arbiter_if bus ();

    dmem_arbiter dut (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (bus)
    );

    // Behavioural data memory with a backdoor preload port
    logic [7:0] mem [64] = '{default: 8'h00};
    logic [7:0] mem_out_q = 8'h00;
    logic       bd_en  = 1'b0;
    logic [5:0] bd_adr = 6'd0;
    logic [7:0] bd_dat = 8'h00;

    always @(posedge clk) begin
        if (bd_en)             mem[bd_adr]       <= bd_dat;
        else if (bus.mem_mode) mem[bus.mem_adrs] <= bus.mem_data;
        mem_out_q <= mem[bus.mem_adrs];
    end
    assign bus.mem_out = mem_out_q;

    int         n_checks = 0;
    int         n_errors = 0;
    logic [7:0] ref_mem [64] = '{default: 8'h00};
    bit         pend [2];
    bit         pwe [2];
    logic [5:0] padr [2];
    logic [7:0] pwd [2];
    logic [7:0] last_rd [2];
    int         rr_fav = 0;

    function automatic logic ack_of(input int i);
        return (i != 0) ? bus.ack1 : bus.ack0;
    endfunction

    function automatic logic [7:0] rdata_of(input int i);
        return (i != 0) ? bus.rdata1 : bus.rdata0;
    endfunction

    task automatic drive_reqs();
        bus.req0 = pend[0]; bus.we0 = pwe[0]; bus.adrs0 = padr[0]; bus.wdata0 = pwd[0];
        bus.req1 = pend[1]; bus.we1 = pwe[1]; bus.adrs1 = padr[1]; bus.wdata1 = pwd[1];
    endtask

    task automatic set_req(input int r, input bit we, input logic [5:0] a, input logic [7:0] d);
        pend[r] = 1'b1; pwe[r] = we; padr[r] = a; pwd[r] = d;
    endtask

    // Called at a negedge with the DUT idle; the next posedge samples the requests.
    task automatic do_txn(input bit early_drop, output int w);
        int lat = 0;
        int mm  = 0;
        int o;
        if (pend[0] && pend[1]) w = rr_fav;
        else if (pend[0])       w = 0;
        else                    w = 1;
`ifdef DMEM_ARB_ROUND_ROBIN_EN
        rr_fav = 1 - w;
`endif
        o = 1 - w;
        drive_reqs();
        for (int cyc = 1; cyc <= 8 && lat == 0; cyc++) begin
            @(posedge clk);
            @(negedge clk);
            if (early_drop && cyc == 1) begin
                pend[w] = 1'b0;
                drive_reqs();
            end
            n_checks++;
            if (bus.gnt_id !== w[0] || bus.mem_adrs !== padr[w] || bus.busy !== 1'b1 ||
                (pwe[w] && bus.mem_data !== pwd[w])) begin
                n_errors++;
                $display("FAIL txn_bus cyc=%0d: gnt=%0d adrs=%0d data=%h busy=%b, want gnt=%0d adrs=%0d data=%h busy=1",
                         cyc, bus.gnt_id, bus.mem_adrs, bus.mem_data, bus.busy, w, padr[w], pwd[w]);
            end
            n_checks++;
            if (ack_of(o) !== 1'b0) begin
                n_errors++;
                $display("FAIL ack_other cyc=%0d: ack%0d=%b, want 0", cyc, o, ack_of(o));
            end
            if (bus.mem_mode === 1'b1) mm++;
            if (ack_of(w) === 1'b1) lat = cyc;
        end
        n_checks++;
        if (lat != (pwe[w] ? 4 : 3)) begin
            n_errors++;
            $display("FAIL latency req%0d we=%0d: got %0d (0=timeout), want %0d", w, pwe[w], lat, pwe[w] ? 4 : 3);
        end
        n_checks++;
        if (mm != (pwe[w] ? 3 : 0)) begin
            n_errors++;
            $display("FAIL mem_mode_cycles req%0d: got %0d, want %0d", w, mm, pwe[w] ? 3 : 0);
        end
        if (pwe[w]) ref_mem[padr[w]] = pwd[w];
        else        last_rd[w] = ref_mem[padr[w]];
        n_checks++;
        if (rdata_of(w) !== last_rd[w] || rdata_of(o) !== last_rd[o]) begin
            n_errors++;
            $display("FAIL rdata at ack of req%0d: rdata%0d=%h rdata%0d=%h, want %h and %h",
                     w, w, rdata_of(w), o, rdata_of(o), last_rd[w], last_rd[o]);
        end
        pend[w] = 1'b0;
        drive_reqs();
        @(posedge clk);
        @(negedge clk);
        n_checks++;
        if (bus.busy !== 1'b0 || bus.ack0 !== 1'b0 || bus.ack1 !== 1'b0) begin
            n_errors++;
            $display("FAIL idle_return: busy=%b ack0=%b ack1=%b, want 0 0 0", bus.busy, bus.ack0, bus.ack1);
        end
    endtask

    task automatic test_reset();
        for (int i = 0; i < 2; i++) begin
            pend[i] = 1'b0; pwe[i] = 1'b0; padr[i] = 6'd0; pwd[i] = 8'h00; last_rd[i] = 8'h00;
        end
        drive_reqs();
        rst_n = 1'b0;
        @(negedge clk);
        bd_en = 1'b1; bd_adr = 6'd5; bd_dat = 8'h3C;
        @(negedge clk);
        bd_en = 1'b0;
        ref_mem[5] = 8'h3C;
        n_checks++;
        if (bus.busy !== 1'b0 || bus.mem_mode !== 1'b0) begin
            n_errors++;
            $display("FAIL reset_ctrl: busy=%b mem_mode=%b, want 0 0", bus.busy, bus.mem_mode);
        end
        n_checks++;
        if (bus.ack0 !== 1'b0 || bus.ack1 !== 1'b0 || bus.gnt_id !== 1'b0) begin
            n_errors++;
            $display("FAIL reset_ack: ack0=%b ack1=%b gnt_id=%b, want 0 0 0", bus.ack0, bus.ack1, bus.gnt_id);
        end
        n_checks++;
        if (bus.mem_adrs !== 6'd0 || bus.mem_data !== 8'h00) begin
            n_errors++;
            $display("FAIL reset_mem_bus: adrs=%0d data=%h, want 0 00", bus.mem_adrs, bus.mem_data);
        end
        n_checks++;
        if (bus.rdata0 !== 8'h00 || bus.rdata1 !== 8'h00) begin
            n_errors++;
            $display("FAIL reset_rdata: rdata0=%h rdata1=%h, want 00 00", bus.rdata0, bus.rdata1);
        end
        rst_n = 1'b1;
        rr_fav = 0;
    endtask

    // Starts on the negedge that released reset, so the first edge must grant.
    task automatic test_read();
        int w;
        set_req(1, 1'b0, 6'd5, 8'h00);
        do_txn(1'b0, w);
        n_checks++;
        if (w != 1 || bus.rdata1 !== 8'h3C) begin
            n_errors++;
            $display("FAIL read_addr5: rdata1=%h, want 3c", bus.rdata1);
        end
    endtask

    task automatic test_write();
        int w;
        set_req(0, 1'b1, 6'd32, 8'hA5);
        do_txn(1'b0, w);
        set_req(1, 1'b0, 6'd32, 8'h00);
        do_txn(1'b0, w);
        n_checks++;
        if (bus.rdata1 !== 8'hA5) begin
            n_errors++;
            $display("FAIL write_readback: rdata1=%h, want a5", bus.rdata1);
        end
    endtask

    task automatic test_contention();
        int w;
        int got [4];
        int exp_order [4];
`ifdef DMEM_ARB_ROUND_ROBIN_EN
        exp_order = '{0, 1, 0, 1};
`else
        exp_order = '{0, 0, 0, 0};
`endif
        set_req(0, 1'b0, 6'd5, 8'h00);
        set_req(1, 1'b0, 6'd32, 8'h00);
        for (int i = 0; i < 4; i++) begin
            do_txn(1'b0, w);
            got[i] = w;
            pend[w] = 1'b1;
        end
        for (int i = 0; i < 4; i++) begin
            n_checks++;
            if (got[i] != exp_order[i]) begin
                n_errors++;
                $display("FAIL contention_order[%0d]: granted %0d, want %0d", i, got[i], exp_order[i]);
            end
        end
        while (pend[0] || pend[1]) do_txn(1'b0, w);
    endtask

    task automatic test_early_drop();
        int w;
        int extra = 0;
        set_req(1, 1'b0, 6'd32, 8'h00);
        do_txn(1'b1, w);
        for (int i = 0; i < 4; i++) begin
            @(posedge clk);
            @(negedge clk);
            if (bus.ack0 !== 1'b0 || bus.ack1 !== 1'b0 || bus.busy !== 1'b0) extra++;
        end
        n_checks++;
        if (bus.rdata1 !== 8'hA5 || extra != 0) begin
            n_errors++;
            $display("FAIL early_drop: rdata1=%h stray_cycles=%0d, want a5 and 0", bus.rdata1, extra);
        end
    endtask

    task automatic test_reset_mid_write();
        int stray = 0;
        set_req(0, 1'b1, 6'd9, 8'h5A);
        drive_reqs();
        @(posedge clk);
        @(negedge clk);
        @(posedge clk);
        @(negedge clk);
        n_checks++;
        if (bus.mem_mode !== 1'b1) begin
            n_errors++;
            $display("FAIL midwrite_pre: mem_mode=%b, want 1", bus.mem_mode);
        end
        rst_n = 1'b0;
        #1;
        n_checks++;
        if (bus.mem_mode !== 1'b0 || bus.busy !== 1'b0) begin
            n_errors++;
            $display("FAIL midwrite_async: mem_mode=%b busy=%b, want 0 0", bus.mem_mode, bus.busy);
        end
        n_checks++;
        if (bus.rdata0 !== 8'h00 || bus.rdata1 !== 8'h00 || bus.gnt_id !== 1'b0 || bus.mem_adrs !== 6'd0) begin
            n_errors++;
            $display("FAIL midwrite_clear: rdata0=%h rdata1=%h gnt=%b adrs=%0d, want 00 00 0 0",
                     bus.rdata0, bus.rdata1, bus.gnt_id, bus.mem_adrs);
        end
        pend[0] = 1'b0;
        drive_reqs();
        ref_mem[9] = 8'h5A;  // one write edge reached memory before the abort
        last_rd[0] = 8'h00;
        last_rd[1] = 8'h00;
        rr_fav = 0;
        @(negedge clk);
        rst_n = 1'b1;
        for (int i = 0; i < 6; i++) begin
            @(posedge clk);
            @(negedge clk);
            if (bus.ack0 !== 1'b0 || bus.ack1 !== 1'b0 || bus.busy !== 1'b0) stray++;
        end
        n_checks++;
        if (stray != 0) begin
            n_errors++;
            $display("FAIL midwrite_no_ack: %0d cycles with ack or busy, want 0", stray);
        end
    endtask

    task automatic new_req(input int r);
        logic [5:0] a;
        a = ($urandom_range(0, 3) == 0) ? 6'($urandom_range(0, 63)) : 6'($urandom_range(0, 7));
        set_req(r, 1'($urandom_range(0, 1)), a, 8'($urandom));
    endtask

    task automatic test_random();
        int w;
        int r;
        for (int k = 0; k < 40; k++) begin
            for (int i = 0; i < 2; i++) begin
                if (!pend[i] && $urandom_range(0, 1) == 1) new_req(i);
            end
            if (!pend[0] && !pend[1]) begin
                r = int'($urandom_range(0, 1));
                new_req(r);
            end
            do_txn($urandom_range(0, 3) == 0, w);
        end
        while (pend[0] || pend[1]) do_txn(1'b0, w);
        for (int a = 0; a < 8; a++) begin
            set_req(a % 2, 1'b0, 6'(a), 8'h00);
            do_txn(1'b0, w);
        end
    endtask

    initial begin
        #100000;
        n_errors++;
        $display("FAIL watchdog: simulation did not complete in time");
        $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
        $fatal(1, "watchdog expired");
    end

    initial begin
        test_reset();
        test_read();
        test_write();
        test_contention();
        test_early_drop();
        test_reset_mid_write();
        test_random();
        $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
        $finish;
    end
endmodule

// File: doc/dmem_arbiter.md
DMEM_ARBITER -- requirements
Module: dmem_arbiter

Interface
REQ-001 clk  input  1  single system clock; all state changes on rising edge.
REQ-002 rst_n  input  1  reset, asynchronous, active-low.
REQ-003 req0 / req1  input  1  access request from requester 0 (CPU core) / requester 1 (stack/loader).
REQ-004 we0 / we1  input  1  1 = write, 0 = read, per requester.
REQ-005 adrs0 / adrs1  input  6  data memory address, per requester.
REQ-006 wdata0 / wdata1  input  8  write data, per requester.
REQ-007 ack0 / ack1  output  1  one-cycle completion pulse, per requester.
REQ-008 rdata0 / rdata1  output  8  read result; valid in the ack cycle and held until that requester's next read completes.
REQ-009 mem_adrs  output  6  address to data memory.
REQ-010 mem_data  output  8  write data to data memory.
REQ-011 mem_mode  output  1  data memory write enable, 1 = write.
REQ-012 mem_out  input  8  data memory read data, valid 2 cycles after mem_adrs is stable.
REQ-013 busy  output  1  high in every state except IDLE.
REQ-014 gnt_id  output  1  index of the requester currently granted; holds the last value when IDLE.

Function
REQ-015 FSM states: IDLE, READ, WRITE, DONE. A 2-bit cycle counter clears on every state entry.
REQ-016 IDLE: a high reqN is sampled as a new request; on grant, register weN/adrsN/wdataN; next state is READ if weN=0, else WRITE.
REQ-017 READ lasts exactly 2 cycles with mem_mode=0; at the end of the 2nd cycle, latch mem_out into rdataN; next state DONE.
REQ-018 WRITE lasts exactly 3 cycles with mem_mode=1 and mem_adrs/mem_data stable; next state DONE.
REQ-019 DONE lasts 1 cycle with ackN=1 for the granted requester only and mem_mode=0; next state IDLE.
REQ-020 Latency from the IDLE cycle that samples req to ack: read 3 cycles, write 4 cycles.
REQ-021 mem_adrs/mem_data come from the registered request; they never change between grant and DONE.
REQ-022 Requester holds req and its fields stable until ack. A req still high in the IDLE cycle after DONE counts as a new request.
REQ-023 Dropping req before ack does not abort the transaction; it completes and ack still pulses.
REQ-024 Only one requester is granted per transaction; the non-granted request waits, and no request is lost.
REQ-025 ack0 and ack1 are never high in the same cycle.

Reset
REQ-026 rst_n=0 forces state IDLE and clears busy, ack0, ack1, mem_mode, mem_adrs, mem_data, rdata0, rdata1 and gnt_id to 0, and sets the priority pointer to 0, immediately and independent of clk.
REQ-027 Reset during WRITE drops mem_mode to 0 asynchronously; the aborted transaction is never acked.
REQ-028 First grant is possible in the first rising edge after rst_n rises.

Configuration
REQ-029 Macro DMEM_ARB_ROUND_ROBIN_EN defined: when both requests are high in IDLE, grant goes to the requester opposite the last granted one (pointer toggles on each grant, reset value favours 0).
REQ-030 Macro DMEM_ARB_ROUND_ROBIN_EN undefined: fixed priority; requester 0 always wins simultaneous requests and no pointer register exists.

Verification
REQ-031 Read: rdata at mem addr 5 = 0x3C, req1=1 we1=0 adrs1=5 -> ack1 exactly 3 cycles after sampling, rdata1=0x3C, mem_mode stays 0.
REQ-032 Write: req0=1 we0=1 adrs0=32 wdata0=0xA5 -> mem_mode=1 for exactly 3 cycles with mem_adrs=32, mem_data=0xA5; ack0 in the 4th cycle; a later read of 32 returns 0xA5.
REQ-033 Contention: req0 and req1 held high with reads, 4 transactions -> RR_EN gives grant order 0,1,0,1; without it, 0,0,0,0 while req0 stays high.
REQ-034 Reset mid-write: rst_n=0 in the 2nd WRITE cycle -> mem_mode=0 and busy=0 with no clock edge, and no ack follows.
REQ-035 Early drop: req1 falls one cycle after grant -> transaction completes, ack1 pulses once, FSM returns to IDLE.
